// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave deframer oversampled in the clk domain, feeding a bank of
// 8-bit parameter registers with auto-incrementing burst read and write.
module spi_reg_bank #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ssel,
    input  logic                  mosi,
    output logic                  miso,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_stb,
    output logic [3:0]            wr_addr
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [4:0] NREGS = 5'(NUM_REGS);
    localparam logic [3:0] LAST  = 4'(NUM_REGS - 1);

    logic [SYNC_STAGES-1:0]   sclk_sync, ssel_sync, mosi_sync;
    logic                     sclk_d, ssel_d;
    logic                     sclk_s, ssel_s, mosi_s;
    logic                     sclk_rise, sclk_fall, ssel_rise, ssel_fall;

    logic [1:0]               state;
    logic [2:0]               bit_cnt;
    logic [7:0]               rx_shift, tx_shift;
    logic [7:0]               rx_byte, rd_data;
    logic [3:0]               addr_ptr, addr_next, rd_addr;
    logic                     is_write, in_range, byte_done;
    logic [NUM_REGS-1:0][7:0] regs;

    // Synchronisers plus one extra stage on sclk/ssel for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ssel_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ssel_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ssel_d    <= ssel_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssel_rise = ssel_s & ~ssel_d;
    assign ssel_fall = ~ssel_s & ssel_d;

    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign byte_done = sclk_rise & ssel_s & (bit_cnt == 3'd7);
    assign in_range  = {1'b0, addr_ptr} < NREGS;
    assign addr_next = (in_range && addr_ptr == LAST) ? 4'd0 : addr_ptr + 4'd1;

    // Read source: the command's address while in CMD, the next address in DATA.
    assign rd_addr = (state == ST_CMD) ? rx_byte[3:0] : addr_next;

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 4'(i)) rd_data = regs[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            addr_ptr <= 4'd0;
            is_write <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= 4'd0;
            regs     <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (sclk_rise && ssel_s) begin
                rx_shift <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
            end
            // Frame end wins over a coincident byte completion.
            if (ssel_fall) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                tx_shift <= 8'h00;
            end else if (ssel_rise) begin
                state   <= ST_CMD;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (byte_done) begin
                            is_write <= rx_byte[7];
                            addr_ptr <= rx_byte[3:0];
                            tx_shift <= rx_byte[7] ? 8'h00 : rd_data;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (byte_done) begin
                            if (is_write && in_range) begin
                                for (int i = 0; i < NUM_REGS; i++)
                                    if (addr_ptr == 4'(i)) regs[i] <= rx_byte;
                                wr_stb  <= 1'b1;
                                wr_addr <= addr_ptr;
                            end
                            addr_ptr <= addr_next;
                            if (!is_write) tx_shift <= rd_data;
                        end else if (sclk_fall && !is_write) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign miso     = (state == ST_DATA) && !is_write && tx_shift[7];
    assign regs_out = regs;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed SPI frames against a transaction-level register-bank model with a
// per-cycle compare process on regs_out, wr_stb/wr_addr and idle/write miso.
module tb_spi_reg_bank;
    localparam int N    = 8;
    localparam int HALF = 8;

    logic           clk = 1'b0;
    logic           rst, sclk, ssel, mosi;
    logic           miso, wr_stb;
    logic [N*8-1:0] regs_out;
    logic [3:0]     wr_addr;

    spi_reg_bank #(.NUM_REGS(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ssel(ssel), .mosi(mosi),
        .miso(miso), .regs_out(regs_out), .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  mreg [16];
    logic [11:0] exp_q [$];
    bit          miso_zero = 1'b1;
    bit          checking  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*8-1:0] model_flat();
        logic [N*8-1:0] f;
        for (int i = 0; i < N; i++) f[i*8 +: 8] = mreg[i];
        return f;
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] a);
        int ai = int'(a);
        if (ai < N) return 4'((ai + 1) % N);
        return 4'((ai + 1) % 16);
    endfunction

    function automatic logic [7:0] model_rd(input logic [3:0] a);
        if (int'(a) < N) return mreg[a];
        return 8'h00;
    endfunction

    // Compare process: one expected write is consumed per wr_stb cycle.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (checking) begin
                if (rst) begin
                    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
                    exp_q.delete();
                    chk("rst_regs", regs_out, '0);
                    chk("rst_wr_stb", wr_stb, 0);
                    chk("rst_wr_addr", wr_addr, 0);
                    chk("rst_miso", miso, 0);
                end else begin
                    if (wr_stb) begin
                        if (exp_q.size() == 0) chk("unexpected_wr_stb", wr_stb, 0);
                        else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", wr_addr, e[11:8]);
                            mreg[e[11:8]] = e[7:0];
                        end
                    end
                    chk("regs_out", regs_out, model_flat());
                    if (miso_zero) chk("miso_zero", miso, 0);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Miso is sampled at the end of each high phase; a read byte's MSB shows
    // up at the last bit of the byte before it.
    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        cyc(HALF);
        sclk = 1'b1;
        cyc(HALF);
        m    = miso;
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [31:0] bytes, input int n, input int extra,
                         output logic [23:0] rd);
        logic       s [64];
        int         k = 0;
        logic [7:0] b, got;
        logic       wr;
        logic [3:0] a;
        b  = bytes[31:24];
        wr = b[7];
        a  = b[3:0];
        rd = '0;
        if (!wr) miso_zero = 1'b0;
        ssel = 1'b1;
        cyc(HALF);
        for (int i = 0; i < n; i++) begin
            b = bytes[31-8*i -: 8];
            if (i > 0 && wr) begin
                if (int'(a) < N) exp_q.push_back({a, b});
                a = nxt(a);
            end
            for (int j = 7; j >= 0; j--) begin
                send_bit(b[j], s[k]);
                k++;
            end
        end
        for (int j = 0; j < extra; j++) begin
            send_bit(j[0], s[k]);
            k++;
        end
        cyc(HALF);
        ssel = 1'b0;
        cyc(HALF);
        miso_zero = 1'b1;
        chk("pending_writes", 64'(exp_q.size()), 0);
        if (!wr) begin
            a = bytes[27:24];
            for (int i = 1; i < n; i++) begin
                for (int m = 0; m < 8; m++) got[7-m] = s[8*i-1+m];
                chk("miso_byte", got, model_rd(a));
                a = nxt(a);
                if (i <= 3) rd[8*(3-i) +: 8] = got;
            end
        end
    endtask

    initial begin
        logic [23:0] rd;
        logic [7:0]  c;
        logic        m;
        rst = 1'b1; sclk = 1'b0; ssel = 1'b0; mosi = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        cyc(2);
        checking = 1'b1;
        cyc(3);
        chk("init_regs_lit", regs_out, 64'h0);
        chk("init_miso_lit", miso, 0);
        rst = 1'b0;
        cyc(5);

        // Single write
        frame(32'h83A50000, 2, 0, rd);
        chk("single_wr_lit", regs_out, 64'h00000000_A5000000);

        // Reset in the middle of a write frame
        c = 8'h81;
        ssel = 1'b1;
        cyc(HALF);
        for (int j = 7; j >= 0; j--) send_bit(c[j], m);
        for (int j = 0; j < 4; j++) send_bit(1'b1, m);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("midrst_regs_lit", regs_out, 64'h0);
        chk("midrst_miso_lit", miso, 0);
        chk("midrst_stb_lit", wr_stb, 0);
        rst = 1'b0;
        cyc(HALF);
        ssel = 1'b0;
        cyc(HALF);
        frame(32'h825A0000, 2, 0, rd);
        chk("post_rst_wr_lit", regs_out, 64'h00000000_005A0000);

        // Burst write wrapping 7 -> 0
        frame(32'h86112233, 4, 0, rd);
        chk("burst_wrap_lit", regs_out, 64'h22110000_005A0033);

        // Preload then read back with auto-increment
        frame(32'h81C33C00, 3, 0, rd);
        chk("preload_lit", regs_out, 64'h22110000_003CC333);
        frame(32'h01000000, 3, 0, rd);
        chk("rd_reg1_lit", rd[23:16], 8'hC3);
        chk("rd_reg2_lit", rd[15:8], 8'h3C);

        // Read crossing the top of the bank
        frame(32'h07000000, 3, 0, rd);
        chk("rd_wrap7_lit", rd[23:16], 8'h22);
        chk("rd_wrap0_lit", rd[15:8], 8'h33);

        // Out-of-range write and read
        frame(32'h8CFF0000, 2, 0, rd);
        chk("oor_wr_lit", regs_out, 64'h22110000_003CC333);
        frame(32'h0C000000, 2, 0, rd);
        chk("oor_rd_lit", rd[23:16], 8'h00);

        // Aborted write after 5 data bits, then a clean write
        frame(32'h84000000, 1, 5, rd);
        chk("abort_lit", regs_out, 64'h22110000_003CC333);
        frame(32'h84770000, 2, 0, rd);
        chk("after_abort_lit", regs_out, 64'h22110077_003CC333);

        cyc(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
